// File: rtl/uart_frame_ram_writer.sv
// Parses framed RAM write commands from a UART byte stream and drives N_CH
// wave-delay RAM write ports, with checksum, inter-byte timeout and error counting.
module uart_frame_ram_writer #(
  parameter int N_CH        = 4,
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 24,
  parameter int TIMEOUT_CYC = 2000,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                     I_clk_10M,
  input  logic                     I_rst_n,
  input  logic [7:0]               I_rx_data,
  input  logic                     I_rx_vld,
  input  logic [4:0]               I_GA,
  output logic [N_CH-1:0]          O_wea,
  output logic [N_CH*ADDR_W-1:0]   O_waddr,
  output logic [N_CH*DATA_W-1:0]   O_wdata,
  output logic                     O_frame_ok,
  output logic                     O_frame_err,
  output logic [ERR_CNT_W-1:0]     O_err_cnt
);

  localparam int DATA_BYTES = (DATA_W + 7) / 8;
  localparam int BCNT_W     = $clog2(DATA_BYTES + 1);
  localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(DATA_BYTES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [8:0]        N_CH_L    = 9'(N_CH);

  typedef enum logic [2:0] {
    S_IDLE, S_GA, S_CH, S_ADDR_H, S_ADDR_L, S_DATA, S_CSUM
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_ga_match;
  logic                  r_ch_valid;
  logic [7:0]            r_ch;
  logic [7:0]            r_csum;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic [BCNT_W-1:0]     r_byte_cnt;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic                  w_frame_ok;
  logic                  w_frame_err;
  logic [N_CH-1:0]       w_sel;
  logic [N_CH-1:0]       w_wea;
  logic [ADDR_W-1:0]     r_waddr [N_CH];
  logic [DATA_W-1:0]     r_wdata [N_CH];

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The terminal timeout count only fires on an idle cycle, so a byte arriving
  // on that same cycle is consumed instead.
  always_comb begin
    w_state_next = r_state;
    w_frame_ok   = 1'b0;
    w_frame_err  = 1'b0;
    if (r_state != S_IDLE && !I_rx_vld && r_tmo_cnt == TMO_LAST) begin
      w_state_next = S_IDLE;
      w_frame_err  = 1'b1;
    end else if (I_rx_vld) begin
      case (r_state)
        S_IDLE:   if (I_rx_data == 8'hAA) w_state_next = S_GA;
        S_GA:     w_state_next = S_CH;
        S_CH:     w_state_next = S_ADDR_H;
        S_ADDR_H: w_state_next = S_ADDR_L;
        S_ADDR_L: w_state_next = S_DATA;
        S_DATA:   if (r_byte_cnt == LAST_BYTE) w_state_next = S_CSUM;
        S_CSUM: begin
          w_state_next = S_IDLE;
          if (r_ga_match) begin
            if (I_rx_data == r_csum && r_ch_valid) w_frame_ok  = 1'b1;
            else                                  w_frame_err = 1'b1;
          end
        end
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_ga_match  <= 1'b0;
      r_ch_valid  <= 1'b0;
      r_ch        <= '0;
      r_csum      <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_byte_cnt  <= '0;
      r_tmo_cnt   <= '0;
      O_wea       <= '0;
      O_frame_ok  <= 1'b0;
      O_frame_err <= 1'b0;
      O_err_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE || I_rx_vld) r_tmo_cnt <= '0;
      else                               r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (I_rx_vld) begin
        case (r_state)
          S_GA: begin
            r_ga_match <= (I_rx_data[4:0] == I_GA) || (I_rx_data == 8'h1F);
            r_csum     <= I_rx_data;
          end
          S_CH: begin
            r_ch       <= I_rx_data;
            r_ch_valid <= ({1'b0, I_rx_data} < N_CH_L) || (I_rx_data == 8'hFF);
            r_csum     <= r_csum ^ I_rx_data;
          end
          S_ADDR_H, S_ADDR_L: begin
            // Shifting both bytes through keeps only the low ADDR_W address bits.
            r_addr     <= ADDR_W'({r_addr, I_rx_data});
            r_csum     <= r_csum ^ I_rx_data;
            r_byte_cnt <= '0;
          end
          S_DATA: begin
            r_data     <= DATA_W'({r_data, I_rx_data});
            r_csum     <= r_csum ^ I_rx_data;
            r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
          end
          default: ;
        endcase
      end

      O_wea       <= w_wea;
      O_frame_ok  <= w_frame_ok;
      O_frame_err <= w_frame_err;
      if (w_frame_err && O_err_cnt != {ERR_CNT_W{1'b1}}) begin
        O_err_cnt <= O_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_sel[gi] = (r_ch == 8'hFF) || (r_ch == 8'(gi));
      assign w_wea[gi] = w_frame_ok && w_sel[gi];

      always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
        if (!I_rst_n) begin
          r_waddr[gi] <= '0;
          r_wdata[gi] <= '0;
        end else if (w_wea[gi]) begin
          r_waddr[gi] <= r_addr;
          r_wdata[gi] <= r_data;
        end
      end

      assign O_waddr[gi*ADDR_W +: ADDR_W] = r_waddr[gi];
      assign O_wdata[gi*DATA_W +: DATA_W] = r_wdata[gi];
    end
  endgenerate

endmodule

// File: tb/tb_uart_frame_ram_writer.sv
// Table-driven, scoreboard-checked bench for uart_frame_ram_writer
// (N_CH=4, ADDR_W=11, DATA_W=24, GA=3).
module tb_uart_frame_ram_writer;

  localparam int N_CH = 4;
  localparam int AW   = 11;
  localparam int DW   = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_vld;
  logic [4:0]        ga;
  logic [N_CH-1:0]   wea;
  logic [N_CH*AW-1:0] waddr;
  logic [N_CH*DW-1:0] wdata;
  logic              frame_ok;
  logic              frame_err;
  logic [7:0]        err_cnt;

  always #50 clk = ~clk;

  uart_frame_ram_writer #(
    .N_CH(N_CH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(2000), .ERR_CNT_W(8)
  ) dut (
    .I_clk_10M(clk), .I_rst_n(rst_n), .I_rx_data(rx_data), .I_rx_vld(rx_vld),
    .I_GA(ga), .O_wea(wea), .O_waddr(waddr), .O_wdata(wdata),
    .O_frame_ok(frame_ok), .O_frame_err(frame_err), .O_err_cnt(err_cnt)
  );

  typedef struct {
    string       name;
    logic [71:0] frame;
    logic [3:0]  wea;
    logic        ok;
    logic        err;
    logic [10:0] addr;
    logic [23:0] data;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] wea;
    logic       ok;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  vec_t  tbl [8];
  exp_t  sb [$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    ok_seen  = 0;
  int    err_seen = 0;
  logic [10:0] m_addr [N_CH];
  logic [23:0] m_data [N_CH];
  int    m_err = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      ok_seen  += int'(frame_ok);
      err_seen += int'(frame_err);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
  endtask

  task automatic drive_frame(input logic [71:0] f);
    for (int i = 0; i < 9; i++) drive_byte(f[71-8*i -: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_vld = 1'b0;
    end
  endtask

  task automatic push_exp(input string nm, input logic [3:0] w, input logic ok,
                          input logic err, input logic [10:0] a, input logic [23:0] d);
    exp_t e;
    if (err && m_err < 255) m_err++;
    for (int k = 0; k < N_CH; k++) begin
      if (w[k]) begin
        m_addr[k] = a;
        m_data[k] = d;
      end
    end
    e.name = nm; e.wea = w; e.ok = ok; e.err = err; e.cnt = 8'(m_err);
    sb.push_back(e);
  endtask

  // Response appears on the cycle after the final byte; pulses must last one cycle.
  task automatic check_resp();
    exp_t e;
    @(negedge clk);
    rx_vld = 1'b0;
    e = sb.pop_front();
    $display("frame %s: wea=%b ok=%b err=%b err_cnt=%0d", e.name, wea, frame_ok, frame_err, err_cnt);
    chk({e.name, " wea"}, wea, e.wea);
    chk({e.name, " ok"}, frame_ok, e.ok);
    chk({e.name, " err"}, frame_err, e.err);
    chk({e.name, " err_cnt"}, err_cnt, e.cnt);
    for (int k = 0; k < N_CH; k++) begin
      chk($sformatf("%s addr ch%0d", e.name, k), waddr[k*AW +: AW], m_addr[k]);
      chk($sformatf("%s data ch%0d", e.name, k), wdata[k*DW +: DW], m_data[k]);
    end
    @(negedge clk);
    chk({e.name, " pulse width"}, {wea, frame_ok, frame_err}, 6'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int o0;
    tbl[0] = '{"unicast",    72'hAA_03_02_01_23_12_34_56_53, 4'b0100, 1'b1, 1'b0, 11'h123, 24'h123456};
    tbl[1] = '{"broadcast",  72'hAA_03_FF_00_05_00_00_0A_F3, 4'b1111, 1'b1, 1'b0, 11'h005, 24'h00000A};
    tbl[2] = '{"bad_csum",   72'hAA_03_02_01_23_12_34_56_54, 4'b0000, 1'b0, 1'b1, 11'h000, 24'h000000};
    tbl[3] = '{"bad_chan",   72'hAA_03_04_01_23_12_34_56_55, 4'b0000, 1'b0, 1'b1, 11'h000, 24'h000000};
    tbl[4] = '{"ga_miss",    72'hAA_04_02_01_23_12_34_56_54, 4'b0000, 1'b0, 1'b0, 11'h000, 24'h000000};
    tbl[5] = '{"global_ga",  72'hAA_1F_01_FF_FF_AB_CD_EF_97, 4'b0010, 1'b1, 1'b0, 11'h7FF, 24'hABCDEF};
    tbl[6] = '{"aa_in_data", 72'hAA_03_00_00_AA_AA_AA_AA_03, 4'b0001, 1'b1, 1'b0, 11'h0AA, 24'hAAAAAA};
    tbl[7] = '{"ga_hi_bits", 72'hAA_E3_01_00_10_00_00_01_F3, 4'b0010, 1'b1, 1'b0, 11'h010, 24'h000001};
    for (int k = 0; k < N_CH; k++) begin
      m_addr[k] = '0;
      m_data[k] = '0;
    end

    rst_n = 1'b0; rx_vld = 1'b0; rx_data = 8'h00; ga = 5'd3;
    repeat (3) @(negedge clk);
    chk("reset wea", wea, 4'b0);
    chk("reset waddr", waddr, '0);
    chk("reset wdata", wdata, '0);
    chk("reset ok", frame_ok, 1'b0);
    chk("reset err", frame_err, 1'b0);
    chk("reset err_cnt", err_cnt, 8'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      drive_frame(tbl[i].frame);
      push_exp(tbl[i].name, tbl[i].wea, tbl[i].ok, tbl[i].err, tbl[i].addr, tbl[i].data);
      check_resp();
    end

    // GA-mismatch frame immediately followed by a new frame on the next cycle
    drive_frame(72'hAA_04_02_01_23_12_34_56_54);
    @(negedge clk);
    chk("b2b miss silent", {wea, frame_ok, frame_err}, 6'b0);
    rx_data = 8'hAA;
    rx_vld  = 1'b1;
    for (int i = 1; i < 9; i++) drive_byte(8'((72'hAA_03_03_02_34_65_43_21_31) >> (64 - 8*i)));
    push_exp("b2b_next", 4'b1000, 1'b1, 1'b0, 11'h234, 24'h654321);
    check_resp();

    // 2000 idle cycles inside a frame: timeout
    drive_byte(8'hAA); drive_byte(8'h03); drive_byte(8'h02);
    e0 = err_seen;
    idle(2000);
    chk("timeout not early", err_seen - e0, 0);
    push_exp("timeout", 4'b0000, 1'b0, 1'b1, 11'h0, 24'h0);
    check_resp();
    drive_frame(tbl[0].frame);
    push_exp("after_timeout", 4'b0100, 1'b1, 1'b0, 11'h123, 24'h123456);
    check_resp();

    // 1999 idle cycles: byte arrives on the terminal cycle and wins
    drive_byte(8'hAA); drive_byte(8'h03); drive_byte(8'h02);
    e0 = err_seen;
    idle(1999);
    drive_byte(8'h01); drive_byte(8'h07); drive_byte(8'h77);
    drive_byte(8'h00); drive_byte(8'h00); drive_byte(8'h53 ^ 8'h23 ^ 8'h07 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h77);
    push_exp("gap_1999", 4'b0100, 1'b1, 1'b0, 11'h107, 24'h770000);
    check_resp();
    chk("gap_1999 no err", err_seen - e0, 0);

    // Reset mid-frame discards the partial frame
    drive_byte(8'hAA); drive_byte(8'h03); drive_byte(8'h02); drive_byte(8'h01);
    @(negedge clk);
    rx_vld = 1'b0;
    rst_n  = 1'b0;
    m_err  = 0;
    for (int k = 0; k < N_CH; k++) begin
      m_addr[k] = '0;
      m_data[k] = '0;
    end
    @(negedge clk);
    $display("reset mid-frame: wea=%b err_cnt=%0d", wea, err_cnt);
    chk("midreset wea", wea, 4'b0);
    chk("midreset waddr", waddr, '0);
    chk("midreset wdata", wdata, '0);
    chk("midreset pulses", {frame_ok, frame_err}, 2'b0);
    chk("midreset err_cnt", err_cnt, 8'd0);
    rst_n = 1'b1;
    e0 = err_seen;
    o0 = ok_seen;
    drive_byte(8'h23); drive_byte(8'h12); drive_byte(8'h34); drive_byte(8'h56); drive_byte(8'h53);
    idle(3);
    chk("midreset tail ok", ok_seen - o0, 0);
    chk("midreset tail err", err_seen - e0, 0);

    // 256 rejected frames: counter saturates
    for (int n = 0; n < 256; n++) begin
      drive_frame(tbl[2].frame);
      push_exp($sformatf("sat%0d", n), 4'b0000, 1'b0, 1'b1, 11'h0, 24'h0);
      check_resp();
    end
    chk("err_cnt saturated", err_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
